// File: rtl/parity_engine.sv
// -----------------------------------------------------------------------------
// parity_engine
//
// Parity generator/checker for the UART datapath.
//
// TX side: a word is captured on Data_Valid (unless Busy is high) together with
// the parity mode in force at that moment. A later Par_En computes the parity
// bit of the captured word, and par_ready then qualifies par_bit. A fresh
// capture always takes priority over a pending compute.
//
// RX side: Chk_Valid checks Chk_Data/Chk_Par against the live Par_Mode. A
// mismatch produces a one-cycle Par_Err pulse and bumps a saturating error
// counter. Err_Clr zeroes the counter and wins over a same-cycle increment.
//
// Parity modes: 00 even, 01 odd, 10 mark (constant 1), 11 space (constant 0).
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   In_Data     TX word to capture
//   Data_Valid  single-cycle load strobe
//   Busy        blocks capture while high
//   Par_En      compute parity of the captured word
//   Par_Mode    parity mode (latched on capture, used live by the checker)
//   par_bit     TX parity bit
//   par_ready   par_bit is valid for the currently captured word
//   Chk_Valid   single-cycle check strobe
//   Chk_Data    received word
//   Chk_Par     received parity bit
//   Err_Clr     synchronous clear of Err_Cnt
//   Par_Err     one-cycle pulse after a mismatching check
//   Err_Cnt     saturating mismatch count
// -----------------------------------------------------------------------------
module parity_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    In_Data,
    input  logic                     Data_Valid,
    input  logic                     Busy,
    input  logic                     Par_En,
    input  logic [1:0]               Par_Mode,
    output logic                     par_bit,
    output logic                     par_ready,
    input  logic                     Chk_Valid,
    input  logic [DATA_WIDTH-1:0]    Chk_Data,
    input  logic                     Chk_Par,
    input  logic                     Err_Clr,
    output logic                     Par_Err,
    output logic [ERR_CNT_WIDTH-1:0] Err_Cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOADED = 2'b01,
        DONE   = 2'b10
    } tx_state_t;

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [1:0]            mode_reg;

    logic                  capture_p0;
    logic                  compute_p0;
    logic                  mismatch_p0;

    // Parity of a word under a given mode; single-cycle XOR reduction.
    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d,
                                      input logic [1:0]            m);
        logic p;
        case (m)
            2'b00:   p = ^d;
            2'b01:   p = ~^d;
            2'b10:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
        input logic [ERR_CNT_WIDTH-1:0] c);
        logic [ERR_CNT_WIDTH-1:0] r;
        if (&c) r = c;
        else    r = c + ERR_CNT_WIDTH'(1);
        return r;
    endfunction

    // Stage 0: request decode. Capture suppresses compute in the same cycle.
    assign capture_p0  = Data_Valid && !Busy;
    assign compute_p0  = (state == LOADED) && Par_En && !capture_p0;
    assign mismatch_p0 = Chk_Valid && (Chk_Par != parity_f(Chk_Data, Par_Mode));

    // Stage 1: TX capture/compute FSM with registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            data_reg  <= '0;
            mode_reg  <= 2'b00;
            par_bit   <= 1'b0;
            par_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (capture_p0) begin
                        data_reg  <= In_Data;
                        mode_reg  <= Par_Mode;
                        par_ready <= 1'b0;
                        state     <= LOADED;
                    end
                end
                LOADED: begin
                    if (capture_p0) begin
                        data_reg  <= In_Data;
                        mode_reg  <= Par_Mode;
                        par_ready <= 1'b0;
                        state     <= LOADED;
                    end else if (compute_p0) begin
                        par_bit   <= parity_f(data_reg, mode_reg);
                        par_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    par_ready <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: checker result and error counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Par_Err <= 1'b0;
            Err_Cnt <= '0;
        end else begin
            Par_Err <= mismatch_p0;
            if (Err_Clr)
                Err_Cnt <= '0;
            else if (mismatch_p0)
                Err_Cnt <= sat_inc(Err_Cnt);
        end
    end

endmodule

// File: tb/tb_parity_engine.sv
// -----------------------------------------------------------------------------
// tb_parity_engine
//
// Directed scenarios followed by a randomized run, all compared each cycle
// against a behavioural model that computes parity by counting ones and keeps
// the TX status and the error count as plain variables.
// -----------------------------------------------------------------------------
module tb_parity_engine;

    localparam int DW = 9;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] In_Data = '0;
    logic          Data_Valid = 1'b0;
    logic          Busy = 1'b0;
    logic          Par_En = 1'b0;
    logic [1:0]    Par_Mode = 2'b00;
    logic          par_bit;
    logic          par_ready;
    logic          Chk_Valid = 1'b0;
    logic [DW-1:0] Chk_Data = '0;
    logic          Chk_Par = 1'b0;
    logic          Err_Clr = 1'b0;
    logic          Par_Err;
    logic [CW-1:0] Err_Cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_data;
    logic [1:0]    m_mode;
    bit            m_pending;   // word captured, parity not yet computed
    logic          m_bit;
    logic          m_ready;
    logic          m_err;
    int            m_cnt;

    parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .In_Data    (In_Data),
        .Data_Valid (Data_Valid),
        .Busy       (Busy),
        .Par_En     (Par_En),
        .Par_Mode   (Par_Mode),
        .par_bit    (par_bit),
        .par_ready  (par_ready),
        .Chk_Valid  (Chk_Valid),
        .Chk_Data   (Chk_Data),
        .Chk_Par    (Chk_Par),
        .Err_Clr    (Err_Clr),
        .Par_Err    (Par_Err),
        .Err_Cnt    (Err_Cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_par(input logic [DW-1:0] d, input logic [1:0] m);
        int ones;
        ones = $countones(d);
        case (m)
            2'b00:   return logic'(ones % 2);
            2'b01:   return logic'(1 - (ones % 2));
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = '0; m_mode = 2'b00; m_pending = 0;
        m_bit = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic check_all(input string where);
        check({where, ".par_bit"},   par_bit,   m_bit);
        check({where, ".par_ready"}, par_ready, m_ready);
        check({where, ".Par_Err"},   Par_Err,   m_err);
        check({where, ".Err_Cnt"},   Err_Cnt,   m_cnt);
    endtask

    // One clock: the model consumes the inputs present at the edge, then the
    // strobes are dropped and all outputs compared.
    task automatic tick(input string where);
        bit mis;
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            if (Data_Valid && !Busy) begin
                m_data = In_Data; m_mode = Par_Mode;
                m_ready = 1'b0; m_pending = 1;
            end else if (m_pending && Par_En) begin
                m_bit = ref_par(m_data, m_mode);
                m_ready = 1'b1; m_pending = 0;
            end
            mis = Chk_Valid && (Chk_Par != ref_par(Chk_Data, Par_Mode));
            m_err = mis;
            if (Err_Clr) m_cnt = 0;
            else if (mis) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        #1;
        Data_Valid = 1'b0; Par_En = 1'b0; Chk_Valid = 1'b0; Err_Clr = 1'b0;
        check_all(where);
    endtask

    task automatic capture(input logic [DW-1:0] d, input logic [1:0] m);
        In_Data = d; Par_Mode = m; Data_Valid = 1'b1; Busy = 1'b0;
        tick("capture");
    endtask

    task automatic compute(input string where);
        Par_En = 1'b1;
        tick(where);
    endtask

    initial begin
        model_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_all("reset");

        // Par_En in IDLE after reset does nothing
        compute("idle_pen");
        check("idle_pen_ready", par_ready, 1'b0);

        // Even/odd on 0xA5 and 0x07
        capture(9'h0A5, 2'b00);
        check("cap_ready_low", par_ready, 1'b0);
        compute("even_a5");
        check("even_a5_bit", par_bit, 1'b0);
        check("even_a5_ready", par_ready, 1'b1);
        capture(9'h0A5, 2'b01);
        check("cap_hold_bit", par_bit, 1'b0);
        compute("odd_a5");
        check("odd_a5_bit", par_bit, 1'b1);
        capture(9'h007, 2'b00);
        compute("even_07");
        check("even_07_bit", par_bit, 1'b1);

        // Mode latched at capture
        capture(9'h007, 2'b10);
        Par_Mode = 2'b11;
        compute("mark_latched");
        check("mark_latched_bit", par_bit, 1'b1);
        capture(9'h007, 2'b11);
        compute("space_07");
        check("space_07_bit", par_bit, 1'b0);

        // Busy-blocked capture, then Par_En in DONE
        In_Data = 9'h0FF; Par_Mode = 2'b00; Busy = 1'b1; Data_Valid = 1'b1;
        tick("busy_drop");
        Busy = 1'b0;
        check("busy_drop_ready", par_ready, 1'b1);
        compute("done_pen");
        check("done_pen_bit", par_bit, 1'b0);
        check("done_pen_ready", par_ready, 1'b1);

        // Capture beats compute in the same cycle; state is LOADED afterwards
        capture(9'h003, 2'b01);
        compute("loaded_first");
        In_Data = 9'h001; Par_Mode = 2'b00; Data_Valid = 1'b1; Par_En = 1'b1;
        tick("cap_vs_pen");
        check("cap_vs_pen_ready", par_ready, 1'b0);
        compute("after_prio");
        check("after_prio_bit", par_bit, 1'b1);
        check("after_prio_ready", par_ready, 1'b1);

        // Checker with 2-bit saturating counter
        Par_Mode = 2'b00; Chk_Data = 9'h001; Chk_Par = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Chk_Valid = 1'b1;
            tick("chk_mis");
            check("chk_mis_err", Par_Err, 1'b1);
            check("chk_mis_cnt", Err_Cnt, (i < 3) ? i + 1 : 3);
        end
        Chk_Par = 1'b1; Chk_Valid = 1'b1;
        tick("chk_ok");
        check("chk_ok_err", Par_Err, 1'b0);
        check("chk_ok_cnt", Err_Cnt, 3);
        tick("chk_idle");
        check("chk_idle_err", Par_Err, 1'b0);

        // Clear together with a mismatch
        Chk_Par = 1'b0; Chk_Valid = 1'b1; Err_Clr = 1'b1;
        tick("clr_vs_err");
        check("clr_vs_err_cnt", Err_Cnt, 0);
        check("clr_vs_err_pulse", Par_Err, 1'b1);

        // Full-width word
        capture(9'h1FF, 2'b00);
        compute("even_1ff");
        check("even_1ff_bit", par_bit, 1'b1);

        // Async reset between capture and Par_En
        Chk_Valid = 1'b1; Chk_Par = 1'b0; Chk_Data = 9'h001; Par_Mode = 2'b00;
        tick("pre_rst_err");
        capture(9'h1FF, 2'b00);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_bit", par_bit, 1'b0);
        check("async_rst_err", Par_Err, 1'b0);
        check("async_rst_cnt", Err_Cnt, 0);
        tick("in_rst");
        RST = 1'b0;
        compute("post_rst_pen");
        check("post_rst_ready", par_ready, 1'b0);
        check("post_rst_bit", par_bit, 1'b0);

        // Randomized traffic on both paths
        for (int i = 0; i < 400; i++) begin
            In_Data    = DW'($urandom);
            Par_Mode   = 2'($urandom_range(0, 3));
            Data_Valid = ($urandom_range(0, 3) == 0);
            Busy       = ($urandom_range(0, 2) == 0);
            Par_En     = ($urandom_range(0, 2) == 0);
            Chk_Valid  = ($urandom_range(0, 1) == 0);
            Chk_Data   = DW'($urandom);
            Chk_Par    = 1'($urandom_range(0, 1));
            Err_Clr    = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        Busy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
